// File: rtl/cpu16_pkg.sv
// cpu16_pkg -- shared definitions for the cpu16 control unit.
//   * opcode constants (4-bit IR op field)
//   * FSM state encoding (7 encoded states in 3 bits; value 7 is unencoded)
//   * ALUop and Regsrc select codes
//   * ctrl_t: bundle of every control output, produced by cpu16_ctrl_decode
package cpu16_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_SLT  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_BNE  = 4'h9;
  localparam logic [3:0] OP_J    = 4'hA;
  localparam logic [3:0] OP_CALL = 4'hB;
  localparam logic [3:0] OP_RET  = 4'hC;
  localparam logic [3:0] OP_IN   = 4'hD;
  localparam logic [3:0] OP_OUT  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLT  = 3'b100;
  localparam logic [2:0] ALU_PASS = 3'b111;

  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_MEM = 2'b01;
  localparam logic [1:0] RS_IO  = 2'b10;
  localparam logic [1:0] RS_RA  = 2'b11;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef struct packed {
    logic       pcsrc;
    logic       writepc;
    logic       writera;
    logic       imrpc;
    logic       memsrc;
    logic       memr1;
    logic       memw1;
    logic       memr2;
    logic       memw2;
    logic       writecr;
    logic [1:0] regsrc;
    logic       backup;
    logic       restore;
    logic       regr1;
    logic       regr2;
    logic       regw1;
    logic       regw2;
    logic       alusrc;
    logic [2:0] aluop;
    logic       cmpeq;
    logic       cmpne;
    logic       resetsig;
  } ctrl_t;

  // R-type opcodes 0..4 map directly onto ALU codes 000..100
  function automatic logic [2:0] rtype_aluop(input logic [3:0] op);
    return op[2:0];
  endfunction

endpackage

// File: rtl/cpu16_ctrl_decode.sv
// cpu16_ctrl_decode -- Moore output map of the control FSM.
//   in : state (state_t), op [3:0]
//   out: c (ctrl_t) -- every control signal; anything not set is 0
// Optional feature: CU_IO_EN enables the in/out opcodes (D/E); without it
// those opcodes assert nothing in EXEC.
import cpu16_pkg::*;

module cpu16_ctrl_decode (
  input  state_t     state,
  input  logic [3:0] op,
  output ctrl_t      c
);

  always_comb begin
    c = '0;
    case (state)
      S_RESET: c.resetsig = 1'b1;
      S_FETCH: begin
        c.memr1   = 1'b1;
        c.writepc = 1'b1;
        c.pcsrc   = 1'b0;
      end
      S_DECODE: begin
        c.regr1 = 1'b1;
        c.regr2 = 1'b1;
      end
      S_EXEC: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: c.aluop = rtype_aluop(op);
          OP_ADDI, OP_LW, OP_SW: begin
            c.alusrc = 1'b1;
            c.aluop  = ALU_ADD;
          end
          OP_BEQ, OP_BNE: begin
            c.aluop   = ALU_SUB;
            c.writecr = 1'b1;
            c.cmpeq   = (op == OP_BEQ);
            c.cmpne   = (op == OP_BNE);
          end
          OP_J, OP_CALL: begin
            c.writepc = 1'b1;
            c.pcsrc   = 1'b1;
            c.imrpc   = 1'b0;
            c.writera = (op == OP_CALL);
            c.backup  = (op == OP_CALL);
          end
          OP_RET: begin
            c.restore = 1'b1;
            c.writepc = 1'b1;
          end
`ifdef CU_IO_EN
          OP_IN: begin
            c.regsrc = RS_IO;
            c.regw1  = 1'b1;
          end
          OP_OUT: c.aluop = ALU_PASS;
`endif
          default: ;
        endcase
      end
      S_MEM: begin
        c.memsrc = 1'b0;
        c.memr2  = (op == OP_LW);
        c.memw2  = (op == OP_SW);
      end
      S_WB: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI: begin
            c.regw1  = 1'b1;
            c.regsrc = RS_ALU;
          end
          OP_LW: begin
            c.regw2  = 1'b1;
            c.regsrc = RS_MEM;
          end
          // PC write is qualified by the compare result inside pms
          OP_BEQ, OP_BNE: begin
            c.writepc = 1'b1;
            c.pcsrc   = 1'b1;
            c.imrpc   = 1'b1;
          end
          default: ;
        endcase
      end
      default: ; // HALT and unencoded states drive nothing
    endcase
  end

endmodule

// File: rtl/cpu16_control.sv
// cpu16_control -- multicycle control FSM for the 16-bit processor.
//   clk, Reset (async, active low), op [3:0] from IR
//   outputs: all pms / ies enables and selects (see cpu16_pkg::ctrl_t)
// State register and next-state logic live here; the output map is in
// cpu16_ctrl_decode. Optional feature macro: CU_IO_EN (in/out opcodes).
import cpu16_pkg::*;

module cpu16_control (
  input  logic       clk,
  input  logic       Reset,
  input  logic [3:0] op,
  output logic       PCsrc,
  output logic       writePC,
  output logic       writeRA,
  output logic       ImRPC,
  output logic       Memsrc,
  output logic       MemR1,
  output logic       MemW1,
  output logic       MemR2,
  output logic       MemW2,
  output logic       writeCR,
  output logic [1:0] Regsrc,
  output logic       backup,
  output logic       restore,
  output logic       RegR1,
  output logic       RegR2,
  output logic       RegW1,
  output logic       RegW2,
  output logic       ALUsrc,
  output logic [2:0] ALUop,
  output logic       cmpeq,
  output logic       cmpne,
  output logic       resetSig
);

  state_t state, state_nxt;
  ctrl_t  c;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state <= S_RESET;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_RESET;
    case (state)
      S_RESET:  state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = (op == OP_HALT) ? S_HALT : S_EXEC;
      S_EXEC: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI,
          OP_BEQ, OP_BNE:  state_nxt = S_WB;
          OP_LW, OP_SW:    state_nxt = S_MEM;
          default:         state_nxt = S_FETCH;
        endcase
      end
      S_MEM:    state_nxt = (op == OP_LW) ? S_WB : S_FETCH;
      S_WB:     state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_RESET; // unencoded value recovers via RESET
    endcase
  end

  cpu16_ctrl_decode u_dec (
    .state (state),
    .op    (op),
    .c     (c)
  );

  assign PCsrc    = c.pcsrc;
  assign writePC  = c.writepc;
  assign writeRA  = c.writera;
  assign ImRPC    = c.imrpc;
  assign Memsrc   = c.memsrc;
  assign MemR1    = c.memr1;
  assign MemW1    = c.memw1;
  assign MemR2    = c.memr2;
  assign MemW2    = c.memw2;
  assign writeCR  = c.writecr;
  assign Regsrc   = c.regsrc;
  assign backup   = c.backup;
  assign restore  = c.restore;
  assign RegR1    = c.regr1;
  assign RegR2    = c.regr2;
  assign RegW1    = c.regw1;
  assign RegW2    = c.regw2;
  assign ALUsrc   = c.alusrc;
  assign ALUop    = c.aluop;
  assign cmpeq    = c.cmpeq;
  assign cmpne    = c.cmpne;
  assign resetSig = c.resetsig;

endmodule

// File: tb/tb_cpu16_control.sv
// tb_cpu16_control -- directed-vector bench for cpu16_control.
// All outputs are packed into one 25-bit word; expected words are built
// from per-signal bit masks written out by hand for each state/opcode.
module tb_cpu16_control;

  logic       clk = 1'b0;
  logic       Reset;
  logic [3:0] op;
  logic       PCsrc, writePC, writeRA, ImRPC, Memsrc, MemR1, MemW1, MemR2, MemW2;
  logic       writeCR, backup, restore, RegR1, RegR2, RegW1, RegW2, ALUsrc;
  logic       cmpeq, cmpne, resetSig;
  logic [1:0] Regsrc;
  logic [2:0] ALUop;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cpu16_control dut (
    .clk(clk), .Reset(Reset), .op(op),
    .PCsrc(PCsrc), .writePC(writePC), .writeRA(writeRA), .ImRPC(ImRPC),
    .Memsrc(Memsrc), .MemR1(MemR1), .MemW1(MemW1), .MemR2(MemR2), .MemW2(MemW2),
    .writeCR(writeCR), .Regsrc(Regsrc), .backup(backup), .restore(restore),
    .RegR1(RegR1), .RegR2(RegR2), .RegW1(RegW1), .RegW2(RegW2),
    .ALUsrc(ALUsrc), .ALUop(ALUop), .cmpeq(cmpeq), .cmpne(cmpne),
    .resetSig(resetSig)
  );

  localparam logic [24:0] B_PCSRC   = 25'h1 << 24;
  localparam logic [24:0] B_WRPC    = 25'h1 << 23;
  localparam logic [24:0] B_WRRA    = 25'h1 << 22;
  localparam logic [24:0] B_IMRPC   = 25'h1 << 21;
  localparam logic [24:0] B_MEMR1   = 25'h1 << 19;
  localparam logic [24:0] B_MEMR2   = 25'h1 << 17;
  localparam logic [24:0] B_MEMW2   = 25'h1 << 16;
  localparam logic [24:0] B_WRCR    = 25'h1 << 15;
  localparam logic [24:0] B_RS_MEM  = 25'h1 << 13;
  localparam logic [24:0] B_RS_IO   = 25'h2 << 13;
  localparam logic [24:0] B_BACKUP  = 25'h1 << 12;
  localparam logic [24:0] B_RESTORE = 25'h1 << 11;
  localparam logic [24:0] B_REGR1   = 25'h1 << 10;
  localparam logic [24:0] B_REGR2   = 25'h1 << 9;
  localparam logic [24:0] B_REGW1   = 25'h1 << 8;
  localparam logic [24:0] B_REGW2   = 25'h1 << 7;
  localparam logic [24:0] B_ALUSRC  = 25'h1 << 6;
  localparam logic [24:0] B_ALU_SUB = 25'h1 << 3;
  localparam logic [24:0] B_ALU_AND = 25'h2 << 3;
  localparam logic [24:0] B_ALU_OR  = 25'h3 << 3;
  localparam logic [24:0] B_ALU_SLT = 25'h4 << 3;
  localparam logic [24:0] B_ALU_PB  = 25'h7 << 3;
  localparam logic [24:0] B_CMPEQ   = 25'h1 << 2;
  localparam logic [24:0] B_CMPNE   = 25'h1 << 1;
  localparam logic [24:0] B_RSTSIG  = 25'h1;

  localparam logic [24:0] E_RESET  = B_RSTSIG;
  localparam logic [24:0] E_FETCH  = B_MEMR1 | B_WRPC;
  localparam logic [24:0] E_DECODE = B_REGR1 | B_REGR2;
  localparam logic [24:0] E_BRWB   = B_WRPC | B_PCSRC | B_IMRPC;
  localparam logic [24:0] E_NONE   = 25'h0;

  function automatic logic [24:0] outs();
    return {PCsrc, writePC, writeRA, ImRPC, Memsrc, MemR1, MemW1, MemR2, MemW2,
            writeCR, Regsrc, backup, restore, RegR1, RegR2, RegW1, RegW2,
            ALUsrc, ALUop, cmpeq, cmpne, resetSig};
  endfunction

  task automatic chk(input string tag, input logic [24:0] got, input logic [24:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called with the FSM sitting in FETCH; runs one instruction back to FETCH.
  task automatic run(input string tag, input logic [3:0] opc,
                     input logic [24:0] e_exec,
                     input bit has_mem, input logic [24:0] e_mem,
                     input bit has_wb,  input logic [24:0] e_wb);
    op = opc;
    step(); chk({tag, " decode"}, outs(), E_DECODE);
    step(); chk({tag, " exec"}, outs(), e_exec);
    if (has_mem) begin step(); chk({tag, " mem"}, outs(), e_mem); end
    if (has_wb)  begin step(); chk({tag, " wb"},  outs(), e_wb);  end
    step(); chk({tag, " fetch"}, outs(), E_FETCH);
  endtask

  initial begin
    logic [24:0] e_in, e_out;
`ifdef CU_IO_EN
    e_in  = B_RS_IO | B_REGW1;
    e_out = B_ALU_PB;
`else
    e_in  = E_NONE;
    e_out = E_NONE;
`endif
    Reset = 1'b0;
    op    = 4'h6;
    #3;
    chk("reset held", outs(), E_RESET);
    step();
    chk("reset held edge", outs(), E_RESET);
    @(negedge clk) Reset = 1'b1;
    step();
    chk("first fetch", outs(), E_FETCH);

    run("lw",   4'h6, B_ALUSRC, 1'b1, B_MEMR2, 1'b1, B_REGW2 | B_RS_MEM);
    run("add",  4'h0, E_NONE,    1'b0, E_NONE, 1'b1, B_REGW1);
    run("sub",  4'h1, B_ALU_SUB, 1'b0, E_NONE, 1'b1, B_REGW1);
    run("and",  4'h2, B_ALU_AND, 1'b0, E_NONE, 1'b1, B_REGW1);
    run("or",   4'h3, B_ALU_OR,  1'b0, E_NONE, 1'b1, B_REGW1);
    run("slt",  4'h4, B_ALU_SLT, 1'b0, E_NONE, 1'b1, B_REGW1);
    run("addi", 4'h5, B_ALUSRC,  1'b0, E_NONE, 1'b1, B_REGW1);
    run("bne",  4'h9, B_ALU_SUB | B_WRCR | B_CMPNE, 1'b0, E_NONE, 1'b1, E_BRWB);
    run("beq",  4'h8, B_ALU_SUB | B_WRCR | B_CMPEQ, 1'b0, E_NONE, 1'b1, E_BRWB);
    run("call", 4'hB, B_WRRA | B_BACKUP | B_WRPC | B_PCSRC, 1'b0, E_NONE, 1'b0, E_NONE);
    run("j",    4'hA, B_WRPC | B_PCSRC, 1'b0, E_NONE, 1'b0, E_NONE);
    run("ret",  4'hC, B_RESTORE | B_WRPC, 1'b0, E_NONE, 1'b0, E_NONE);
    run("in",   4'hD, e_in,  1'b0, E_NONE, 1'b0, E_NONE);
    run("out",  4'hE, e_out, 1'b0, E_NONE, 1'b0, E_NONE);
    run("sw",   4'h7, B_ALUSRC, 1'b1, B_MEMW2, 1'b0, E_NONE);

    // sw interrupted by reset while in MEM
    op = 4'h7;
    step(); chk("sw2 decode", outs(), E_DECODE);
    step(); chk("sw2 exec", outs(), B_ALUSRC);
    step(); chk("sw2 mem", outs(), B_MEMW2);
    Reset = 1'b0;
    #1;
    chk("sw2 async reset", outs(), E_RESET);
    @(negedge clk) Reset = 1'b1;
    step(); chk("sw2 refetch", outs(), E_FETCH);

    // halt holds with everything low until reset
    op = 4'hF;
    step(); chk("halt decode", outs(), E_DECODE);
    for (int i = 0; i < 10; i++) begin
      step(); chk("halt hold", outs(), E_NONE);
    end
    Reset = 1'b0;
    #1;
    chk("halt reset", outs(), E_RESET);
    @(negedge clk) Reset = 1'b1;
    op = 4'h0;
    step(); chk("halt refetch", outs(), E_FETCH);
    run("add after halt", 4'h0, E_NONE, 1'b0, E_NONE, 1'b1, B_REGW1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
